// File: rtl/io16_pkg.sv
// Shared constants, channel state encoding and counter-width helper for the IO16 switch debouncer.
package io16_pkg;

    localparam int unsigned NUM_CH_DEF = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } ch_state_e;

    // Counter must hold DEBOUNCE_TICKS-1; a single-tick debounce still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned ticks);
        return (ticks <= 1) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: multi-flop synchroniser, tick-driven debounce counter and
// IDLE/PENDING FSM producing the debounced level plus rise/fall strobes.
module debounce_channel
    import io16_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_TICKS = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic change_c
);

    localparam int unsigned        CNT_W    = cnt_width(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   mismatch;
    logic                   do_count;
    ch_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_d, rise_d, fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync     = sync_q[SYNC_STAGES-1];
    assign mismatch = sync ^ stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stable  <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stable  <= stable_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // A tick landing in the cycle the mismatch first appears is already counted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        do_count = 1'b0;

        case (state_q)
            IDLE: begin
                if (mismatch) begin
                    state_d  = PENDING;
                    do_count = 1'b1;
                end
            end
            PENDING: begin
                if (!mismatch) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    do_count = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_count && tick) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync;
                cnt_d    = '0;
                rise_d   = sync;
                fall_d   = ~sync;
                state_d  = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign change_c = rise_d | fall_d;

endmodule

// File: rtl/io16_switch_debounce.sv
// 16-channel switch/button conditioner feeding the IO expander S1..S16 inputs.
// Define IO16_TOGGLE_EN to turn each debounced rising edge into a latching toggle on SW_STABLE.
module io16_switch_debounce
    import io16_pkg::*;
#(
    parameter int unsigned NUM_CH         = NUM_CH_DEF,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_TICKS = 10000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLK_1MHz,
    input  logic [NUM_CH-1:0] SW_RAW,
    output logic [NUM_CH-1:0] SW_STABLE,
    output logic [NUM_CH-1:0] SW_RISE,
    output logic [NUM_CH-1:0] SW_FALL,
    output logic              ANY_CHANGE
);

    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] change_c;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_ch (
            .clk     (CLK),
            .rst_n   (RST_N),
            .tick    (CLK_1MHz),
            .raw     (SW_RAW[i]),
            .stable  (level[i]),
            .rise    (SW_RISE[i]),
            .fall    (SW_FALL[i]),
            .change_c(change_c[i])
        );
    end

    // Registered alongside the per-channel strobes so all three line up.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ANY_CHANGE <= 1'b0;
        end else begin
            ANY_CHANGE <= |change_c;
        end
    end

`ifdef IO16_TOGGLE_EN
    // A pending change while the level is low is a debounced rising edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SW_STABLE <= '0;
        end else begin
            SW_STABLE <= SW_STABLE ^ (change_c & ~level);
        end
    end
`else
    assign SW_STABLE = level;
`endif

endmodule

// File: tb/tb_io16_switch_debounce.sv
// Directed bench for io16_switch_debounce: DEBOUNCE_TICKS=4, SYNC_STAGES=2, tick every 4th clock.
module tb_io16_switch_debounce;

    logic        CLK;
    logic        RST_N;
    logic        CLK_1MHz;
    logic [15:0] SW_RAW;
    logic [15:0] SW_STABLE;
    logic [15:0] SW_RISE;
    logic [15:0] SW_FALL;
    logic        ANY_CHANGE;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    io16_switch_debounce #(
        .NUM_CH        (16),
        .SYNC_STAGES   (2),
        .DEBOUNCE_TICKS(4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CLK_1MHz  (CLK_1MHz),
        .SW_RAW    (SW_RAW),
        .SW_STABLE (SW_STABLE),
        .SW_RISE   (SW_RISE),
        .SW_FALL   (SW_FALL),
        .ANY_CHANGE(ANY_CHANGE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; the tick for the next edge is high when that edge index is a multiple of 4.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        CLK_1MHz = ((cyc + 1) % 4 == 0);
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic align();
        while (cyc % 4 != 0) step();
    endtask

    logic [15:0] bad;
    logic [15:0] exp_tog;

    initial begin
        RST_N    = 1'b0;
        CLK_1MHz = 1'b0;
        SW_RAW   = 16'h0000;
        bad      = 16'h0000;
        exp_tog  = 16'h0000;
        steps(3);
        chk("reset_stable", SW_STABLE, 16'h0000);
        chk("reset_rise", SW_RISE, 16'h0000);
        chk("reset_fall", SW_FALL, 16'h0000);
        chk("reset_any", {15'b0, ANY_CHANGE}, 16'h0000);
        RST_N = 1'b1;

`ifdef IO16_TOGGLE_EN
        // Three press/release cycles on S3: toggle goes 1, 0, 1; each release gives a fall strobe.
        for (int p = 0; p < 3; p++) begin
            exp_tog = exp_tog ^ 16'h0004;
            align();
            SW_RAW = 16'h0004;
            steps(15);
            chk("tog_press_early", SW_STABLE, exp_tog ^ 16'h0004);
            step();
            chk("tog_press_stable", SW_STABLE, exp_tog);
            chk("tog_press_rise", SW_RISE, 16'h0004);
            align();
            SW_RAW = 16'h0000;
            steps(16);
            chk("tog_release_stable", SW_STABLE, exp_tog);
            chk("tog_release_fall", SW_FALL, 16'h0004);
        end
`else
        // All channels rise together after 2 sync cycles + 4 ticks.
        align();
        SW_RAW = 16'hFFFF;
        steps(15);
        chk("all_rise_early", SW_STABLE, 16'h0000);
        step();
        chk("all_rise_stable", SW_STABLE, 16'hFFFF);
        chk("all_rise_rise", SW_RISE, 16'hFFFF);
        chk("all_rise_fall", SW_FALL, 16'h0000);
        chk("all_rise_any", {15'b0, ANY_CHANGE}, 16'h0001);
        step();
        chk("all_rise_rise_end", SW_RISE, 16'h0000);
        chk("all_rise_any_end", {15'b0, ANY_CHANGE}, 16'h0000);

        // Asynchronous mid-cycle reset clears outputs without a clock edge.
        step();
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_stable", SW_STABLE, 16'h0000);
        chk("async_rst_rise", SW_RISE, 16'h0000);
        chk("async_rst_any", {15'b0, ANY_CHANGE}, 16'h0000);
        steps(2);
        align();
        RST_N = 1'b1;
        steps(15);
        chk("rst_release_early", SW_STABLE, 16'h0000);
        step();
        chk("rst_release_stable", SW_STABLE, 16'hFFFF);
        chk("rst_release_rise", SW_RISE, 16'hFFFF);
        chk("rst_release_any", {15'b0, ANY_CHANGE}, 16'h0001);
        step();
        chk("rst_release_rise_end", SW_RISE, 16'h0000);

        // All channels fall back to 0.
        align();
        SW_RAW = 16'h0000;
        steps(15);
        chk("all_fall_early", SW_STABLE, 16'hFFFF);
        step();
        chk("all_fall_stable", SW_STABLE, 16'h0000);
        chk("all_fall_fall", SW_FALL, 16'hFFFF);
        chk("all_fall_rise", SW_RISE, 16'h0000);
        step();
        chk("all_fall_fall_end", SW_FALL, 16'h0000);

        // Clean edge on S1 only.
        align();
        SW_RAW = 16'h0001;
        steps(15);
        chk("s1_rise_early", SW_STABLE, 16'h0000);
        step();
        chk("s1_rise_stable", SW_STABLE, 16'h0001);
        chk("s1_rise_rise", SW_RISE, 16'h0001);
        step();
        chk("s1_rise_rise_end", SW_RISE, 16'h0000);
        align();
        SW_RAW = 16'h0000;
        steps(16);
        chk("s1_fall_stable", SW_STABLE, 16'h0000);
        chk("s1_fall_fall", SW_FALL, 16'h0001);
        step();
        chk("s1_fall_fall_end", SW_FALL, 16'h0000);

        // S4 bounces every 5 cycles for 40 cycles, then settles high.
        align();
        for (int k = 0; k < 8; k++) begin
            SW_RAW[3] = (k % 2 == 0);
            for (int j = 0; j < 5; j++) begin
                step();
                bad = bad | SW_STABLE | SW_RISE | SW_FALL;
            end
        end
        chk("bounce_no_change", bad, 16'h0000);
        align();
        SW_RAW[3] = 1'b1;
        steps(15);
        chk("bounce_settle_early", SW_STABLE, 16'h0000);
        step();
        chk("bounce_settle_stable", SW_STABLE, 16'h0008);
        chk("bounce_settle_rise", SW_RISE, 16'h0008);
        align();
        SW_RAW = 16'h0000;
        steps(17);
        chk("bounce_restore", SW_STABLE, 16'h0000);

        // S6: mismatch removed on the edge carrying the 4th tick (counter=3) -> no change, counter cleared.
        align();
        SW_RAW[5] = 1'b1;
        steps(13);
        SW_RAW[5] = 1'b0;
        steps(3);
        chk("collide_stable", SW_STABLE, 16'h0000);
        chk("collide_rise", SW_RISE, 16'h0000);
        align();
        SW_RAW[5] = 1'b1;
        steps(15);
        chk("collide_recount_early", SW_STABLE, 16'h0000);
        step();
        chk("collide_recount_stable", SW_STABLE, 16'h0020);
        align();
        SW_RAW = 16'h0000;
        steps(17);
        chk("collide_restore", SW_STABLE, 16'h0000);

        // S8: reset after 3 counted ticks discards the partial count.
        align();
        SW_RAW[7] = 1'b1;
        steps(12);
        RST_N = 1'b0;
        step();
        chk("midrst_stable", SW_STABLE, 16'h0000);
        RST_N = 1'b1;
        steps(14);
        chk("midrst_early", SW_STABLE, 16'h0000);
        step();
        chk("midrst_stable_after", SW_STABLE, 16'h0080);
        chk("midrst_rise", SW_RISE, 16'h0080);
        align();
        SW_RAW = 16'h0000;
        steps(17);
        chk("midrst_restore", SW_STABLE, 16'h0000);

        // Eight channels rise in the same cycle with one ANY_CHANGE pulse.
        align();
        SW_RAW = 16'hA5A5;
        steps(15);
        chk("multi_any_before", {15'b0, ANY_CHANGE}, 16'h0000);
        step();
        chk("multi_stable", SW_STABLE, 16'hA5A5);
        chk("multi_rise", SW_RISE, 16'hA5A5);
        chk("multi_any", {15'b0, ANY_CHANGE}, 16'h0001);
        step();
        chk("multi_any_after", {15'b0, ANY_CHANGE}, 16'h0000);
        chk("multi_rise_after", SW_RISE, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/io16_switch_debounce.md
Name: io16_switch_debounce

Overview:
- Upstream conditioning stage for the 16-channel IO expander; feeds its S1..S16 inputs.
- Per channel: synchronises raw board switch/button levels into the CLK domain and filters contact bounce using the CLK_1MHz tick.
- Outputs debounced levels plus single-cycle rise/fall strobes, so downstream logic sees clean, glitch-free levels.

Parameters:
- NUM_CH, 16, number of switch channels.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; legal values are 2 or more.
- DEBOUNCE_TICKS, 10000, consecutive CLK_1MHz ticks an input must hold a new level before it is accepted (10 ms). Legal values are 1 or more.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- CLK_1MHz  in  1  tick enable, high for exactly one CLK cycle per microsecond.
- SW_RAW  in  NUM_CH  raw asynchronous switch levels; bit 0 = S1.
- SW_STABLE  out  NUM_CH  debounced levels, registered; connects to S1..S16.
- SW_RISE  out  NUM_CH  one-CLK pulse when SW_STABLE bit goes 0->1.
- SW_FALL  out  NUM_CH  one-CLK pulse when SW_STABLE bit goes 1->0.
- ANY_CHANGE  out  1  OR of SW_RISE and SW_FALL, registered in the same cycle as they are.

Behaviour:
- Reset: RST_N low clears asynchronously all synchroniser flops, counters, SW_STABLE, SW_RISE, SW_FALL and ANY_CHANGE to 0.
- Reset mid-count: any partial count is discarded.
- Synchroniser: SW_RAW[i] passes through SYNC_STAGES flops. sync[i] is the last stage.
- Channels operate independently. Each channel uses a counter of width CNT_W = clog2(DEBOUNCE_TICKS).
- States per channel:
  - IDLE: sync == stable. Counter held at 0.
  - PENDING: sync != stable.
- Transitions:
  - IDLE -> PENDING when sync differs from stable.
  - In PENDING, if sync returns to equal stable in any cycle (bounce), the counter clears to 0 in that cycle and the channel returns to IDLE.
  - In PENDING, on each cycle with CLK_1MHz=1:
    - If counter == DEBOUNCE_TICKS-1: stable <= sync, counter <= 0, the matching RISE/FALL bit pulses high for the next cycle only, and the channel returns to IDLE.
    - Otherwise: counter increments.
- Simultaneous tick and bounce: the bounce (mismatch removed) takes priority. No increment, counter cleared.
- Latency from a clean SW_RAW edge to SW_STABLE change: SYNC_STAGES cycles plus DEBOUNCE_TICKS ticks. The change occurs at the CLK edge that samples the DEBOUNCE_TICKS-th tick while in PENDING.
- The first tick counted may be a partial microsecond. Jitter is at most one tick.
- SW_RISE and SW_FALL are mutually exclusive per bit and never exceed one cycle.
- Multiple channels may strobe in the same cycle. ANY_CHANGE reflects the OR of all of them.
- If CLK_1MHz is held high continuously, ticks count every cycle. This mode is legal and is used for simulation speed-up.

Optional Feature:
- Macro: IO16_TOGGLE_EN.
- Defined: SW_STABLE is replaced by a toggle register per channel. Each debounced rising edge inverts that bit, so push buttons act as latching switches. The toggle register resets to 0. SW_RISE, SW_FALL and ANY_CHANGE keep their debounced-edge meaning.
- Undefined: SW_STABLE follows the debounced level directly. No toggle logic is synthesised.

Decomposition:
- Package io16_pkg holds:
  - NUM_CH default constant.
  - CNT_W computation function (clog2).
  - Channel-state enum {IDLE, PENDING}.
- Sub-module debounce_channel: single-bit synchroniser, counter and FSM, producing stable/rise/fall. The top-level io16_switch_debounce instantiates it NUM_CH times with a generate loop and ORs the strobes into ANY_CHANGE.

Test Plan (bench uses DEBOUNCE_TICKS=4, SYNC_STAGES=2, CLK_1MHz pulsed every 4 CLK cycles):
- Reset: assert RST_N=0 asynchronously mid-cycle with SW_RAW=16'hFFFF -> all outputs 0 immediately. Release with SW_RAW held -> SW_STABLE=16'hFFFF after 2 cycles + 4 ticks; SW_RISE=16'hFFFF for exactly 1 cycle; ANY_CHANGE=1 for that cycle.
- Clean edge: SW_RAW[0] 0->1 and held -> SW_STABLE[0]=1 at the 4th tick after sync; SW_RISE[0] pulses once. Other bits unchanged. Then 1->0 -> SW_FALL[0] pulses once.
- Bounce: SW_RAW[3] toggles 1/0 every 5 cycles for 40 cycles, then settles at 1 -> no SW_STABLE[3] change during bouncing; change only 4 full ticks after settling.
- Tick/bounce collision: return sync[5] to the stable value in the same cycle as a tick with counter=3 -> SW_STABLE[5] unchanged; counter reads 0.
- Reset mid-count: SW_RAW[7]=1 for 3 ticks, pulse RST_N low for 1 cycle -> SW_STABLE[7] stays 0; full 4 ticks required after release. Multi-channel: SW_RAW=16'hA5A5 simultaneously -> all 8 rises in the same cycle, single ANY_CHANGE pulse.
- With IO16_TOGGLE_EN: three debounced press/release cycles on SW_RAW[2] -> SW_STABLE[2] sequence 1, 0, 1; SW_FALL[2] pulses on each release.
